// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and memory write bus of the program loader.
//
//   in_valid  : stream byte valid               (source -> loader)
//   in_data   : stream byte                     (source -> loader)
//   in_ready  : loader accepts a byte this cycle (loader -> source)
//   mem_addr  : memory write address            (loader -> memory)
//   mem_wdata : memory write data               (loader -> memory)
//   mem_wr    : one-cycle write strobe per word (loader -> memory)
//
// The slave modport is the loader's view. The master modport is the view of
// whatever drives the stream and observes the memory bus.
interface prog_loader_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
);
    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_ready;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic              mem_wr;

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_addr, mem_wdata, mem_wr
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_addr, mem_wdata, mem_wr
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the 32x8 RISC core.
//
// The loader accepts a framed byte stream: a length byte N, then N data bytes,
// then a checksum byte. The data bytes are written to memory starting at
// address 0. If the checksum matches, the loader releases the core from reset
// and watches it until the core raises halt or the run-cycle budget runs out.
//
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   start       : level-sampled; starts a load from IDLE, DONE or ERR
//   bus         : stream handshake and memory write bus (prog_loader_if.slave)
//   cpu_rst     : core reset; low only in RUN and DONE
//   cpu_halt    : core halt flag
//   busy        : high in HDR, DATA, CHK and RUN
//   done, err   : high in DONE / ERR respectively
//   err_code    : 0 none, 1 bad length, 2 checksum mismatch, 3 timeout
//   run_cycles  : number of cycles spent in RUN during the last run
module prog_loader #(
    parameter int AWIDTH  = 5,
    parameter int DWIDTH  = 8,
    parameter int TWIDTH  = 16,
    parameter int TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    prog_loader_if.slave      bus,
    output logic              cpu_rst,
    input  logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [TWIDTH-1:0] run_cycles
);

    typedef enum logic [2:0] {
        IDLE, HDR, DATA, CHK, RUN, DONE, ERR
    } state_t;

    localparam logic [31:0]       MAX_LEN = 32'(2 ** AWIDTH);
    localparam logic [TWIDTH-1:0] TO_CNT  = TWIDTH'(TIMEOUT);

    state_t              state;
    logic [AWIDTH:0]     remaining;   // holds up to 2**AWIDTH
    logic [DWIDTH-1:0]   sum;
    logic [AWIDTH-1:0]   mem_addr_r;
    logic [DWIDTH-1:0]   mem_wdata_r;
    logic                mem_wr_r;
    logic [1:0]          err_code_r;
    logic [TWIDTH-1:0]   run_cycles_r;

    logic                in_ready_d;
    logic                beat;
    logic                len_ok;
    logic [TWIDTH-1:0]   rc_inc;

    // Status outputs decode the state register only, so none of them has a
    // combinational path from any input.
    assign in_ready_d = (state == HDR) || (state == DATA) || (state == CHK);
    assign busy       = in_ready_d || (state == RUN);
    assign done       = (state == DONE);
    assign err        = (state == ERR);
    // The core stays out of reset in DONE so its state can be inspected.
    assign cpu_rst    = !((state == RUN) || (state == DONE));

    assign beat   = bus.in_valid && in_ready_d;
    assign len_ok = (bus.in_data != '0) && (32'(bus.in_data) <= MAX_LEN);
    assign rc_inc = run_cycles_r + TWIDTH'(1);

    assign bus.in_ready  = in_ready_d;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_wr    = mem_wr_r;
    assign err_code      = err_code_r;
    assign run_cycles    = run_cycles_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= '0;
            sum          <= '0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            mem_wr_r     <= 1'b0;
            err_code_r   <= 2'd0;
            run_cycles_r <= '0;
        end else begin
            mem_wr_r <= 1'b0;
            // The address steps once a write pulse has been presented, so it
            // holds the word's address for the whole pulse. After a full
            // 2**AWIDTH image it wraps back to 0.
            if (mem_wr_r)
                mem_addr_r <= mem_addr_r + AWIDTH'(1);

            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= HDR;
                        sum          <= '0;
                        mem_addr_r   <= '0;
                        run_cycles_r <= '0;
                        err_code_r   <= 2'd0;
                    end
                end

                HDR: begin
                    if (beat) begin
                        if (len_ok) begin
                            state     <= DATA;
                            remaining <= (AWIDTH + 1)'(bus.in_data);
                        end else begin
                            state      <= ERR;
                            err_code_r <= 2'd1;
                        end
                    end
                end

                DATA: begin
                    if (beat) begin
                        mem_wr_r    <= 1'b1;
                        mem_wdata_r <= bus.in_data;
                        sum         <= sum + bus.in_data;
                        remaining   <= remaining - (AWIDTH + 1)'(1);
                        // The pulse for the last word falls in the first CHK cycle.
                        if (remaining == (AWIDTH + 1)'(1))
                            state <= CHK;
                    end
                end

                CHK: begin
                    if (beat) begin
                        if (bus.in_data == sum) begin
                            state <= RUN;
                        end else begin
                            state      <= ERR;
                            err_code_r <= 2'd2;
                        end
                    end
                end

                RUN: begin
                    // Every RUN cycle is counted, including the cycle in which
                    // halt is seen. If halt arrives on the timeout cycle, halt
                    // takes priority.
                    run_cycles_r <= rc_inc;
                    if (cpu_halt) begin
                        state <= DONE;
                    end else if (rc_inc == TO_CNT) begin
                        state      <= ERR;
                        err_code_r <= 2'd3;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader. Expected memory writes
// are queued as each data byte is driven, then checked in order as mem_wr
// pulses appear.
module tb_prog_loader;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int TW = 16;
    localparam int TO = 4095;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          cpu_halt;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [TW-1:0] run_cycles;

    prog_loader_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    prog_loader #(.AWIDTH(AW), .DWIDTH(DW), .TWIDTH(TW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .cpu_rst    (cpu_rst),
        .cpu_halt   (cpu_halt),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int nwr        = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_e;
    logic [7:0]       img[32];

    // Scoreboard: each write pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.mem_wr === 1'b1) begin
            nwr++;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL wr_unexpected: addr=%0d data=%02h, no write expected",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== mon_e) begin
                    mismatched++;
                    $display("FAIL wr_data: got addr=%0d data=%02h, want addr=%0d data=%02h",
                             bus.mem_addr, bus.mem_wdata, mon_e[AW+DW-1:DW], mon_e[DW-1:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte and hold it until a beat has happened.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            compared++;
            mismatched++;
            $display("FAIL in_ready_wait: in_ready=%b after %0d cycles, want 1", bus.in_ready, n);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic idle_gap(input int maxg);
        if (maxg > 0) tick(int'($urandom_range(maxg, 0)));
    endtask

    function automatic logic [7:0] img_sum(input int n);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < n; i++) s = s + img[i];
        return s;
    endfunction

    // Send length, data and checksum, queuing the expected writes.
    task automatic send_image(input int n, input int maxg, input logic [7:0] chk);
        logic [AW-1:0] a = '0;
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            idle_gap(maxg);
            exp_q.push_back({a, img[i]});
            a = a + 1'b1;
            send_byte(img[i]);
        end
        idle_gap(maxg);
        send_byte(chk);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        start        = 1'b0;
        cpu_halt     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h5A;
        tick(3);
        compared++;
        if ({bus.in_ready, bus.mem_wr, cpu_rst, busy, done, err} !== 6'b001000) begin
            mismatched++;
            $display("FAIL reset_flags: rdy,wr,cpu_rst,busy,done,err=%b want 001000",
                     {bus.in_ready, bus.mem_wr, cpu_rst, busy, done, err});
        end
        compared++;
        if ({bus.mem_addr, bus.mem_wdata, err_code, run_cycles} !== '0) begin
            mismatched++;
            $display("FAIL reset_regs: addr=%0d wdata=%02h code=%0d rc=%0d, want all 0",
                     bus.mem_addr, bus.mem_wdata, err_code, run_cycles);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        int c;
        int nwr0 = nwr;
        img[0] = 8'hA1; img[1] = 8'h05; img[2] = 8'hE0;
        pulse_start();
        compared++;
        if ({busy, bus.in_ready, cpu_rst} !== 3'b111) begin
            mismatched++;
            $display("FAIL basic_hdr: busy,rdy,cpu_rst=%b want 111", {busy, bus.in_ready, cpu_rst});
        end
        send_byte(8'd3);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({AW'(i), img[i]});
            send_byte(img[i]);
        end
        compared++;
        if (cpu_rst !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_cpu_rst_chk: cpu_rst=%b want 1", cpu_rst);
        end
        send_byte(8'h86);
        compared++;
        if (cpu_rst !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_cpu_rst_run: cpu_rst=%b want 0", cpu_rst);
        end
        c = 1;
        while (c < 40) begin
            tick(1);
            c++;
        end
        cpu_halt = 1'b1;
        tick(1);
        cpu_halt = 1'b0;
        compared++;
        if ({done, busy, cpu_rst, run_cycles} !== {3'b100, TW'(40)}) begin
            mismatched++;
            $display("FAIL basic_done: done=%b busy=%b cpu_rst=%b rc=%0d want 1,0,0,40",
                     done, busy, cpu_rst, run_cycles);
        end
        compared++;
        if (nwr - nwr0 != 3 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL basic_writes: writes=%0d pending=%0d want 3,0", nwr - nwr0, exp_q.size());
        end
    endtask

    task automatic test_bad_len();
        logic [7:0] lens[2];
        lens[0] = 8'd0;
        lens[1] = 8'd33;
        for (int k = 0; k < 2; k++) begin
            int nwr0 = nwr;
            pulse_start();
            compared++;
            if ({err, err_code} !== 3'b000) begin
                mismatched++;
                $display("FAIL badlen_clear: err=%b code=%0d want 0,0", err, err_code);
            end
            send_byte(lens[k]);
            tick(2);
            compared++;
            if ({err, err_code, bus.in_ready, cpu_rst} !== 5'b10101 || nwr != nwr0) begin
                mismatched++;
                $display("FAIL badlen_%0d: err=%b code=%0d rdy=%b cpu_rst=%b writes=%0d want 1,1,0,1,0",
                         lens[k], err, err_code, bus.in_ready, cpu_rst, nwr - nwr0);
            end
        end
    endtask

    task automatic test_bad_chk();
        int nwr0 = nwr;
        logic seen_release = 1'b0;
        img[0] = 8'h10; img[1] = 8'h20;
        pulse_start();
        send_image(2, 0, 8'h31);
        for (int i = 0; i < 5; i++) begin
            if (cpu_rst !== 1'b1) seen_release = 1'b1;
            tick(1);
        end
        compared++;
        if ({err, err_code, seen_release} !== 4'b1100) begin
            mismatched++;
            $display("FAIL badchk: err=%b code=%0d cpu_rst_fell=%b want 1,2,0", err, err_code, seen_release);
        end
        compared++;
        if (nwr - nwr0 != 2 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL badchk_writes: writes=%0d pending=%0d want 2,0", nwr - nwr0, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int c;
        for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
        pulse_start();
        send_image(4, 0, img_sum(4));
        c = 1;
        while (err !== 1'b1 && done !== 1'b1 && c < 5000) begin
            tick(1);
            c++;
        end
        compared++;
        if ({err, done, err_code, cpu_rst} !== 5'b10111 || run_cycles !== TW'(TO) || c - 1 != TO) begin
            mismatched++;
            $display("FAIL timeout: err=%b done=%b code=%0d cpu_rst=%b rc=%0d cycles=%0d want 1,0,3,1,%0d,%0d",
                     err, done, err_code, cpu_rst, run_cycles, c - 1, TO, TO);
        end
        // Reload from ERR; the core halts on its first RUN cycle.
        for (int i = 0; i < 3; i++) img[i] = 8'($urandom);
        pulse_start();
        compared++;
        if ({err, err_code, run_cycles} !== '0) begin
            mismatched++;
            $display("FAIL timeout_restart: err=%b code=%0d rc=%0d want 0,0,0", err, err_code, run_cycles);
        end
        send_image(3, 1, img_sum(3));
        cpu_halt = 1'b1;
        tick(1);
        cpu_halt = 1'b0;
        compared++;
        if ({done, cpu_rst} !== 2'b10 || run_cycles !== TW'(1)) begin
            mismatched++;
            $display("FAIL timeout_reload: done=%b cpu_rst=%b rc=%0d want 1,0,1", done, cpu_rst, run_cycles);
        end
    endtask

    task automatic test_full();
        int nwr0 = nwr;
        for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
        pulse_start();
        send_image(32, 3, img_sum(32));
        compared++;
        if ({cpu_rst, err} !== 2'b00 || bus.mem_addr !== AW'(0)) begin
            mismatched++;
            $display("FAIL full_accept: cpu_rst=%b err=%b addr=%0d want 0,0,0", cpu_rst, err, bus.mem_addr);
        end
        compared++;
        if (nwr - nwr0 != 32 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL full_writes: writes=%0d pending=%0d want 32,0", nwr - nwr0, exp_q.size());
        end
        cpu_halt = 1'b1;
        tick(1);
        cpu_halt = 1'b0;
    endtask

    task automatic test_reset_mid();
        int nwr0;
        for (int i = 0; i < 8; i++) img[i] = 8'($urandom);
        pulse_start();
        send_byte(8'd8);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({AW'(i), img[i]});
            send_byte(img[i]);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        compared++;
        if ({bus.in_ready, bus.mem_wr, cpu_rst, busy, done, err} !== 6'b001000 ||
            {bus.mem_addr, bus.mem_wdata, err_code, run_cycles} !== '0) begin
            mismatched++;
            $display("FAIL midrst: rdy,wr,cpu_rst,busy,done,err=%b addr=%0d wdata=%02h want 001000,0,0",
                     {bus.in_ready, bus.mem_wr, cpu_rst, busy, done, err}, bus.mem_addr, bus.mem_wdata);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL midrst_pending: pending=%0d want 0", exp_q.size());
        end
        nwr0 = nwr;
        for (int i = 0; i < 3; i++) img[i] = 8'($urandom);
        pulse_start();
        send_image(3, 2, img_sum(3));
        cpu_halt = 1'b1;
        tick(1);
        cpu_halt = 1'b0;
        compared++;
        if (done !== 1'b1 || nwr - nwr0 != 3 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL midrst_reload: done=%b writes=%0d pending=%0d want 1,3,0",
                     done, nwr - nwr0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_len();
        test_bad_chk();
        test_timeout();
        test_full();
        test_reset_mid();
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
